// File: rtl/breadboard.sv
// Four-way intersection controller: day/night round-robin service of lane pairs,
// pedestrian crossing phase and emergency-vehicle preemption.
module breadboard (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  hoursIn,
    input  logic        pedSignal,
    input  logic        emgSignal,
    input  logic [7:0]  emgLane,
    input  logic [63:0] lanes,
    output logic [7:0]  trafficLightOutput
);

    localparam logic [1:0] MODE_DAY   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_PED   = 2'b10;
    localparam logic [1:0] MODE_EMG   = 2'b11;

    logic [6:0] dayLoadTime, nightLoadTime, emgLoadTime, pedLoadTime, loadIn;
    assign dayLoadTime   = 7'd20;
    assign nightLoadTime = 7'd10;
    assign emgLoadTime   = 7'd5;
    assign pedLoadTime   = 7'd8;

    logic [1:0] trafficMode, trafficModeNext;
    logic [6:0] currentCount, countNext;
    logic [1:0] dirPtr, dirPtrNext, advPtr;
    logic       pedLatch, pedLatchNext;
    logic [7:0] lightNext;
    logic [7:0] walkingLightOutput;
    logic       dayNightSignal;
    logic [1:0] expiryMode;
    logic       enterMode;
    logic [3:0] pairBusy;

    assign dayNightSignal = (hoursIn >= 5'd20) || (hoursIn <= 5'd5);

    // Pair sums are 9 bits wide so two full lanes never wrap to zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gPair
            logic [8:0] pairSum;
            assign pairSum      = {1'b0, lanes[16*gi+7 -: 8]} + {1'b0, lanes[16*gi+15 -: 8]};
            assign pairBusy[gi] = |pairSum;
        end
    endgenerate

    // First busy direction after the current one; the current one is tried last.
    always_comb begin
        advPtr = dirPtr + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            if (pairBusy[dirPtr + k[1:0]])
                advPtr = dirPtr + k[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trafficMode        <= MODE_DAY;
            currentCount       <= 7'd20;
            dirPtr             <= 2'd0;
            pedLatch           <= 1'b0;
            trafficLightOutput <= 8'b0000_0011;
        end else begin
            trafficMode        <= trafficModeNext;
            currentCount       <= countNext;
            dirPtr             <= dirPtrNext;
            pedLatch           <= pedLatchNext;
            trafficLightOutput <= lightNext;
        end
    end

    always_comb begin
        if (emgSignal)
            expiryMode = MODE_EMG;
        else if (pedLatch)
            expiryMode = MODE_PED;
        else if (dayNightSignal)
            expiryMode = MODE_NIGHT;
        else
            expiryMode = MODE_DAY;

        trafficModeNext = trafficMode;
        enterMode       = 1'b0;
        if (emgSignal && trafficMode != MODE_EMG) begin
            trafficModeNext = MODE_EMG;
            enterMode       = 1'b1;
        end else if (currentCount == 7'd0) begin
            trafficModeNext = expiryMode;
            enterMode       = 1'b1;
        end

        case (trafficModeNext)
            MODE_DAY:   loadIn = dayLoadTime;
            MODE_NIGHT: loadIn = nightLoadTime;
            MODE_PED:   loadIn = pedLoadTime;
            default:    loadIn = emgLoadTime;
        endcase

        countNext    = currentCount - 7'd1;
        dirPtrNext   = dirPtr;
        pedLatchNext = pedLatch | pedSignal;
        // Interlock: vehicle greens are never held while walk lights are on.
        lightNext    = trafficLightOutput & ~walkingLightOutput;

        if (enterMode) begin
            countNext = loadIn;
            case (trafficModeNext)
                MODE_EMG: lightNext = emgLane;
                MODE_PED: begin
                    lightNext    = 8'h00;
                    pedLatchNext = 1'b0;
                end
                default: begin
                    dirPtrNext = advPtr;
                    lightNext  = 8'(2'b11) << {advPtr, 1'b0};
                end
            endcase
        end else if (trafficMode == MODE_EMG) begin
            lightNext = emgLane;
        end
    end

    always_comb begin
        walkingLightOutput = (trafficMode == MODE_PED) ? 8'hFF : 8'h00;
    end

endmodule

// File: tb/tb_breadboard.sv
// Scoreboarded bench for breadboard: a behavioural model predicts mode, count and
// lights for every clock; a monitor compares them one cycle later.
module tb_breadboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  hoursIn;
    logic        pedSignal;
    logic        emgSignal;
    logic [7:0]  emgLane;
    logic [63:0] lanes;
    logic [7:0]  trafficLightOutput;

    breadboard dut (
        .clk(clk), .rst(rst), .hoursIn(hoursIn), .pedSignal(pedSignal),
        .emgSignal(emgSignal), .emgLane(emgLane), .lanes(lanes),
        .trafficLightOutput(trafficLightOutput)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int count;
        int out;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int errs = 0;

    logic [7:0] ln [8];
    int  mMode, mCount, mDir, mOut;
    bit  mPed;

    function automatic void chk(string name, int act, int expv);
        vectors++;
        if (act != expv) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
        end
    endfunction

    function automatic int nextDir();
        for (int k = 1; k <= 4; k++) begin
            int d = (mDir + k) % 4;
            if (int'(ln[2*d]) + int'(ln[2*d+1]) > 0) return d;
        end
        return (mDir + 1) % 4;
    endfunction

    function automatic void modelReset();
        mMode = 0; mCount = 20; mDir = 0; mOut = 3; mPed = 0;
    endfunction

    // Predict the state after the coming rising edge from the current inputs.
    function automatic void modelStep();
        bit night, enteredPed;
        night = (hoursIn >= 20) || (hoursIn <= 5);
        enteredPed = 0;
        if (emgSignal && mMode != 3) begin
            mMode = 3; mCount = 5; mOut = emgLane;
        end else if (mCount == 0) begin
            if (emgSignal)  mMode = 3;
            else if (mPed)  mMode = 2;
            else if (night) mMode = 1;
            else            mMode = 0;
            if (mMode == 3) begin
                mCount = 5; mOut = emgLane;
            end else if (mMode == 2) begin
                mCount = 8; mOut = 0; enteredPed = 1;
            end else begin
                mDir = nextDir();
                mCount = (mMode == 1) ? 10 : 20;
                mOut = 3 << (2 * mDir);
            end
        end else begin
            mCount = mCount - 1;
            if (mMode == 3) mOut = emgLane;
        end
        mPed = enteredPed ? 1'b0 : (mPed | pedSignal);
    endfunction

    // Called at a falling edge: apply inputs, predict, then advance one clock.
    task automatic tick(input bit r);
        exp_t e;
        rst = r;
        for (int i = 0; i < 8; i++) lanes[8*i +: 8] = ln[i];
        if (!r) modelReset();
        else    modelStep();
        e.mode = mMode; e.count = mCount; e.out = mOut;
        q.push_back(e);
        if (!r) begin
            #1;
            chk("async reset mode", int'(dut.trafficMode), 0);
            chk("async reset count", int'(dut.currentCount), 20);
            chk("async reset lights", int'(trafficLightOutput), 3);
        end
        @(negedge clk);
    endtask

    task automatic waitMode(input int m, input int lim);
        for (int i = 0; i < lim && int'(dut.trafficMode) != m; i++) tick(1);
        chk("reach mode", int'(dut.trafficMode), m);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb mode", int'(dut.trafficMode), e.mode);
                chk("sb count", int'(dut.currentCount), e.count);
                chk("sb lights", int'(trafficLightOutput), e.out);
                chk("sb walk", int'(dut.walkingLightOutput), (e.mode == 2) ? 255 : 0);
                chk("sb dayNight", int'(dut.dayNightSignal), ((hoursIn >= 20) || (hoursIn <= 5)) ? 1 : 0);
            end
        end
    end

    initial begin : stim
        int prevOut;
        rst = 1'b0; hoursIn = 5'd12; pedSignal = 1'b0; emgSignal = 1'b0; emgLane = 8'h00;
        for (int i = 0; i < 8; i++) ln[i] = 8'd0;
        // w1=48 (lane 7), w2=14 (lane 6), s1=3 (lane 5), n2=15 (lane 0)
        ln[7] = 8'd48; ln[6] = 8'd14; ln[5] = 8'd3; ln[0] = 8'd15;
        for (int i = 0; i < 8; i++) lanes[8*i +: 8] = ln[i];
        modelReset();
        @(negedge clk);
        chk("reset mode", int'(dut.trafficMode), 0);
        chk("reset count", int'(dut.currentCount), 20);
        chk("reset lights", int'(trafficLightOutput), 8'h03);
        chk("reset walk", int'(dut.walkingLightOutput), 0);

        repeat (21) tick(1);
        chk("day S mode", int'(dut.trafficMode), 0);
        chk("day S lights", int'(trafficLightOutput), 8'h30);
        chk("day S count", int'(dut.currentCount), 20);

        repeat (3) tick(1);
        emgSignal = 1'b1; emgLane = 8'b0000_1000;
        tick(1);
        chk("emg entry mode", int'(dut.trafficMode), 3);
        chk("emg entry lights", int'(trafficLightOutput), 8'h08);
        chk("emg entry count", int'(dut.currentCount), 5);
        repeat (12) tick(1);
        chk("emg held mode", int'(dut.trafficMode), 3);
        emgSignal = 1'b0;
        waitMode(0, 10);
        chk("emg exit W lights", int'(trafficLightOutput), 8'hC0);

        hoursIn = 5'd22;
        #1;
        chk("dayNight immediate", int'(dut.dayNightSignal), 1);
        waitMode(1, 30);
        chk("night count", int'(dut.currentCount), 10);
        chk("night loadIn", int'(dut.loadIn), 10);
        repeat (11) tick(1);
        chk("night interval mode", int'(dut.trafficMode), 1);
        chk("night interval count", int'(dut.currentCount), 10);

        pedSignal = 1'b1; tick(1); pedSignal = 1'b0;
        waitMode(2, 15);
        chk("ped lights", int'(trafficLightOutput), 0);
        chk("ped walk", int'(dut.walkingLightOutput), 8'hFF);
        chk("ped count", int'(dut.currentCount), 8);
        repeat (9) tick(1);
        chk("ped exit mode", int'(dut.trafficMode), 1);

        hoursIn = 5'd12;
        for (int i = 0; i < 8; i++) ln[i] = 8'd0;
        waitMode(0, 15);
        prevOut = int'(trafficLightOutput);
        for (int r = 0; r < 4; r++) begin
            repeat (21) tick(1);
            prevOut = ((prevOut << 2) | (prevOut >> 6)) & 8'hFF;
            chk("empty rotate", int'(trafficLightOutput), prevOut);
        end

        pedSignal = 1'b1; tick(1); pedSignal = 1'b0;
        for (int i = 0; i < 25 && dut.currentCount != 7'd0; i++) tick(1);
        chk("expiry reached", int'(dut.currentCount), 0);
        emgSignal = 1'b1; emgLane = 8'h81;
        tick(1);
        chk("emg before ped", int'(dut.trafficMode), 3);
        emgSignal = 1'b0;
        waitMode(2, 10);

        tick(0);
        tick(1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0)
                for (int i = 0; i < 8; i++) ln[i] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 49) == 0) hoursIn = 5'($urandom);
            if ($urandom_range(0, 59) == 0) emgSignal = ~emgSignal;
            if ($urandom_range(0, 9) == 0) emgLane = 8'($urandom);
            pedSignal = ($urandom_range(0, 29) == 0);
            tick(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
        end

        @(posedge clk);
        #2;
        chk("scoreboard drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
